// File: rtl/vga_pkg.sv
// Frame geometry and fetch FSM encoding shared by the framebuffer fetch path.
package vga_pkg;
    localparam int H_A_VID         = 640;
    localparam int V_A_VID         = 480;
    localparam int WORD_W          = 32;
    localparam int ADDR_W          = 14;
    localparam int PIX_PER_FRAME   = H_A_VID * V_A_VID;
    localparam int WORDS_PER_FRAME = PIX_PER_FRAME / WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/pixel_fetch_if.sv
// Framebuffer read port: request/grant address phase, in-order read data phase.
interface pixel_fetch_if #(
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int WORD_W = vga_pkg::WORD_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/pixel_fetch_fifo.sv
// Prefetch FIFO between memory read data and the pixel shift register.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 wdata_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_push = push_i & !full_o;
    assign do_pop  = pop_i & !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            // Pointers wrap explicitly so DEPTH need not be a power of two.
            if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/pixel_fetch.sv
// Streams a 1bpp 640x480 framebuffer from memory into a per-pixel bit for the
// timing generator, prefetching words through a small FIFO.
module pixel_fetch #(
    parameter int WORD_W     = vga_pkg::WORD_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = vga_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_adv,
    pixel_fetch_if.master mem,
    output logic          img_reg,
    output logic          underflow
);
    import vga_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = 8;
    localparam int BW = $clog2(WORD_W + 1);
    localparam int PW = $clog2(PIX_PER_FRAME);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     out_q, out_d;
    logic [DW-1:0]     disc_q, disc_d;
    logic [PW-1:0]     pix_q, pix_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              unf_q, unf_d;

    logic              active, issue, rv_drop, push, load, consume, last_pix;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occ;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;

    assign active   = (state_q != IDLE);
    assign occ      = {1'b0, fifo_cnt} + {1'b0, out_q};
    assign issue    = mem.mem_req & mem.mem_gnt;
    assign rv_drop  = mem.mem_rvalid & (disc_q != '0);
    assign push     = mem.mem_rvalid & (disc_q == '0) & !frame_start;
    assign consume  = active & pix_adv & !frame_start;
    // Reload when empty, or in the same cycle the last bit leaves, so no bubble.
    assign load     = active & !frame_start & !fifo_empty &
                      ((bcnt_q == '0) | (consume & (bcnt_q == BW'(1))));
    assign last_pix = consume & (pix_q == PW'(PIX_PER_FRAME - 1));

    fetch_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (frame_start),
        .push_i  (push),
        .wdata_i (mem.mem_rdata),
        .pop_i   (load),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_start)                   state_d = FILL;
        else if (last_pix)                 state_d = IDLE;
        else if (state_q == FILL && load)  state_d = RUN;
    end

    always_comb begin
        mem.mem_req  = active & !fifo_full & (occ < (CW+1)'(FIFO_DEPTH)) &
                       (addr_q < ADDR_W'(WORDS_PER_FRAME));
        mem.mem_addr = addr_q;
        // The shift register fills with zeros as it drains, so bit 0 is 0 when empty.
        img_reg      = sr_q[0];
        underflow    = unf_q;
    end

    always_comb begin
        addr_d = addr_q;
        out_d  = out_q;
        disc_d = disc_q;
        pix_d  = pix_q;
        sr_d   = sr_q;
        bcnt_d = bcnt_q;
        unf_d  = unf_q;
        if (frame_start) begin
            addr_d = '0;
            out_d  = '0;
            pix_d  = '0;
            sr_d   = '0;
            bcnt_d = '0;
            // Every read still in flight after this edge belongs to the old frame.
            disc_d = disc_q + DW'(out_q) + DW'(issue) - DW'(mem.mem_rvalid);
        end else begin
            if (issue)   addr_d = addr_q + 1'b1;
            out_d = out_q + CW'(issue) - CW'(push);
            if (rv_drop) disc_d = disc_q - 1'b1;
            if (consume) begin
                pix_d = pix_q + 1'b1;
                if (bcnt_q == '0) unf_d = 1'b1;
            end
            if (load) begin
                sr_d   = fifo_rdata;
                bcnt_d = BW'(WORD_W);
            end else if (consume && bcnt_q != '0) begin
                sr_d   = sr_q >> 1;
                bcnt_d = bcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            out_q  <= '0;
            disc_q <= '0;
            pix_q  <= '0;
            sr_q   <= '0;
            bcnt_q <= '0;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            pix_q  <= pix_d;
            sr_q   <= sr_d;
            bcnt_q <= bcnt_d;
            unf_q  <= unf_d;
        end
    end
endmodule
